// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// the index-width helper used for the owner and round-robin pointer.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Bits needed to hold an index in [0, value-1]; never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection. The search starts at 'start' and wraps
// around, so tying 'start' to zero gives plain lowest-index priority.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [IDX_W-1:0]  start,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  index,
  output logic              any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // First valid channel at or after 'start', wrapping modulo NUM_CH.
  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no
    // path through this block can leave a value unassigned (no latches).
    grant = '0;
    index = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, start} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_CH)) sum = sum - (IDX_W + 1)'(NUM_CH);
      cand = sum[IDX_W-1:0];
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port among NUM_CH requesters, one transaction
// at a time: accept in IDLE, hold the strobes in ACCESS until mem_response,
// pulse rsp_valid to the owner in RESP.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the lowest-index requester always wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         busy,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic                         mem_read_en,
  output logic                         mem_write_en,
  output logic [DATA_WIDTH-1:0]        mem_write_val,
  input  logic [DATA_WIDTH-1:0]        mem_read_val,
  input  logic                         mem_response
);

  localparam int IDX_W = clog2(NUM_CH);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    write_q;
  logic [IDX_W-1:0]        start;
  logic [NUM_CH-1:0]       win_grant;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_any;
  logic                    accept;
  logic                    complete;

  mem_arb_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .valid (req_valid),
    .start (start),
    .grant (win_grant),
    .index (win_idx),
    .any   (win_any)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;

  assign start = ptr_q;

  // Rotate the search start to just past the channel that was accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (accept) begin
      if (win_idx == IDX_W'(NUM_CH - 1)) ptr_q <= '0;
      else                               ptr_q <= win_idx + 1'b1;
    end
  end
`else
  assign start = '0;
`endif

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sampled at this edge sees the pre-edge value of every other one.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus all handshake and strobe outputs, decoded from state.
  always_comb begin
    state_d      = state_q;
    req_ready    = '0;
    rsp_valid    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    accept       = 1'b0;
    complete     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          req_ready = win_grant;
          accept    = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        mem_read_en  = ~write_q;
        mem_write_en = write_q;
        if (mem_response) begin
          complete = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request on accept; capture read data on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= win_idx;
        addr_q  <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
        write_q <= req_write[win_idx];
      end
      if (complete && !write_q) rdata_q <= mem_read_val;
    end
  end

  assign busy          = (state_q != IDLE);
  assign mem_addr      = addr_q;
  assign mem_write_val = wdata_q;
  assign rsp_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NUM_CH=2). A transaction-level
// model predicts every output each cycle; directed scenarios add literal
// expectations. Honours MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

  localparam int NUM_CH = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] req_valid;
  logic [NUM_CH-1:0] req_write;
  logic [NUM_CH*AW-1:0] req_addr;
  logic [NUM_CH*DW-1:0] req_wdata;
  logic [NUM_CH-1:0] req_ready;
  logic [NUM_CH-1:0] rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              busy;
  logic [AW-1:0]     mem_addr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DW-1:0]     mem_write_val;
  logic [DW-1:0]     mem_read_val;
  logic              mem_response;

  int errors = 0;
  int checks = 0;
  bit auto_rsp = 1'b0;
  int grants[$];

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .busy          (busy),
    .mem_addr      (mem_addr),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .mem_write_val (mem_write_val),
    .mem_read_val  (mem_read_val),
    .mem_response  (mem_response)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy;
  bit          m_resp;
  int          m_owner;
  bit          m_wr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_ptr;

  function automatic int pick(input logic [NUM_CH-1:0] v, input int first);
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      c = (first + i) % NUM_CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_resp = 0; m_owner = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_ptr = 0;
  endtask

  // Compare at the falling edge, advance the model at the rising edge.
  initial begin
    logic [NUM_CH-1:0] e_ready, e_rsp;
    int w;
    model_clear();
    forever begin
      @(negedge clk);
      if (!reset) model_clear();
      e_ready = '0;
      e_rsp   = '0;
      if (reset && !m_busy) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) e_ready[w] = 1'b1;
      end
      if (m_busy && m_resp) e_rsp[m_owner] = 1'b1;
      check("m_req_ready", 64'(req_ready), 64'(e_ready));
      check("m_rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      check("m_busy", 64'(busy), 64'(m_busy));
      check("m_rd_en", 64'(mem_read_en), 64'(m_busy && !m_resp && !m_wr));
      check("m_wr_en", 64'(mem_write_en), 64'(m_busy && !m_resp && m_wr));
      check("m_addr", 64'(mem_addr), 64'(m_addr));
      check("m_wval", 64'(mem_write_val), 64'(m_wdata));
      check("m_rdata", 64'(rsp_rdata), 64'(m_rdata));
      @(posedge clk);
      if (reset) begin
        if (!m_busy) begin
          w = pick(req_valid, m_ptr);
          if (w >= 0) begin
            m_busy  = 1; m_resp = 0; m_owner = w;
            m_wr    = req_write[w];
            m_addr  = req_addr[w*AW +: AW];
            m_wdata = req_wdata[w*DW +: DW];
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_ptr = (w + 1) % NUM_CH;
`endif
          end
        end else if (!m_resp) begin
          if (mem_response) begin
            if (!m_wr) m_rdata = mem_read_val;
            m_resp = 1;
          end
        end else begin
          m_busy = 0; m_resp = 0;
        end
      end
    end
  end

  // Simple memory that answers in the first cycle a strobe is seen.
  initial forever begin
    @(posedge clk);
    #1;
    if (auto_rsp) mem_response = mem_read_en | mem_write_en;
  end

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    mem_response = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Both channels request; collect the order of accepts.
  task automatic run_contention(input bit drop, input int n);
    int budget;
    logic [NUM_CH-1:0] r;
    budget = 0;
    grants.delete();
    req_write = '0;
    req_addr  = {32'h0000_0104, 32'h0000_0100};
    mem_read_val = 32'h5A5A_0001;
    auto_rsp  = 1'b1;
    req_valid = 2'b11;
    while (grants.size() < n && budget < 100) begin
      @(negedge clk);
      r = req_ready;
      if (r[0]) grants.push_back(0);
      else if (r[1]) grants.push_back(1);
      tick();
      if (drop) req_valid = req_valid & ~r;
      budget++;
    end
    req_valid = '0;
    check("cont_budget", 64'(budget < 100), 64'd1);
    budget = 0;
    while (busy && budget < 20) begin
      tick();
      budget++;
    end
    check("cont_drain", 64'(busy), 64'd0);
    auto_rsp = 1'b0;
    tick();
    mem_response = 1'b0;
  endtask

  initial begin
    int pulses;
    int budget;
    int exp_held[4];
    reset = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_read_val = '0; mem_response = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rd_en", 64'(mem_read_en), 64'd0);
    check("rst_wr_en", 64'(mem_write_en), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Single read on ch1, response in the second ACCESS cycle.
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 32'h40;
    @(negedge clk); check("rd_ready", 64'(req_ready), 64'h2);
    tick(); req_valid = '0;
    @(negedge clk); check("rd_en_c1", 64'(mem_read_en), 64'd1);
    check("rd_addr", 64'(mem_addr), 64'h40);
    tick(); mem_response = 1'b1; mem_read_val = 32'hDEAD_BEEF;
    @(negedge clk); check("rd_en_c2", 64'(mem_read_en), 64'd1);
    tick(); mem_response = 1'b0;
    @(negedge clk); check("rd_rsp", 64'(rsp_valid), 64'h2);
    check("rd_data", 64'(rsp_rdata), 64'hDEAD_BEEF);
    tick();

    // Write on ch0; read data must be left alone.
    req_valid = 2'b01; req_write = 2'b01; req_addr[0 +: AW] = 32'h10;
    req_wdata[0 +: DW] = 32'h1234_5678;
    @(negedge clk); check("wr_ready", 64'(req_ready), 64'h1);
    tick(); req_valid = '0; mem_response = 1'b1;
    @(negedge clk); check("wr_en", 64'(mem_write_en), 64'd1);
    check("wr_rd_en", 64'(mem_read_en), 64'd0);
    check("wr_val", 64'(mem_write_val), 64'h1234_5678);
    tick(); mem_response = 1'b0;
    @(negedge clk); check("wr_rsp", 64'(rsp_valid), 64'h1);
    check("wr_rdata_kept", 64'(rsp_rdata), 64'hDEAD_BEEF);
    tick();

    // Contention, each requester drops after its accept.
    do_reset();
    run_contention(1'b1, 2);
    for (int i = 0; i < grants.size(); i++) check("cont_drop_order", 64'(grants[i]), 64'(i));

    // Both held for four transactions.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_held = '{0, 1, 0, 1};
`else
    exp_held = '{0, 0, 0, 0};
`endif
    do_reset();
    run_contention(1'b0, 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      check("cont_held_order", 64'(grants[i]), 64'(exp_held[i]));

    // Slow memory: ten cycles of strobe before the response.
    pulses = 0;
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 32'h200;
    mem_read_val = 32'hCAFE_F00D;
    @(negedge clk); check("slow_ready", 64'(req_ready), 64'h2);
    tick(); req_valid = '0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) mem_response = 1'b1;
      @(negedge clk);
      check("slow_rd_en", 64'(mem_read_en), 64'd1);
      check("slow_busy", 64'(busy), 64'd1);
      if (rsp_valid != 0) pulses++;
      tick();
    end
    mem_response = 1'b0;
    @(negedge clk); check("slow_rsp", 64'(rsp_valid), 64'h2);
    check("slow_data", 64'(rsp_rdata), 64'hCAFE_F00D);
    if (rsp_valid != 0) pulses++;
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      if (rsp_valid != 0) pulses++;
    end
    check("slow_pulses", 64'(pulses), 64'd1);
    tick();

    // Reset asserted while the read strobe is up.
    req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: AW] = 32'h80;
    @(negedge clk); check("mrst_ready", 64'(req_ready), 64'h1);
    tick(); req_valid = '0;
    tick();
    check("mrst_pre_en", 64'(mem_read_en), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mrst_rd_en", 64'(mem_read_en), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) pulses++;
      tick();
    end
    check("mrst_no_rsp", 64'(pulses), 64'd0);
    auto_rsp = 1'b1; mem_read_val = 32'h0BAD_F00D;
    req_valid = 2'b10; req_addr[AW +: AW] = 32'h300;
    @(negedge clk); check("mrst_new_ready", 64'(req_ready), 64'h2);
    tick(); req_valid = '0;
    budget = 0;
    while (rsp_valid == 0 && budget < 20) begin
      @(negedge clk);
      if (rsp_valid == 0) begin
        tick();
        budget++;
      end
    end
    check("mrst_new_rsp", 64'(rsp_valid), 64'h2);
    check("mrst_new_data", 64'(rsp_rdata), 64'h0BAD_F00D);
    auto_rsp = 1'b0;
    tick();
    tick();
    mem_response = 1'b0;

    // Spurious response while idle.
    mem_response = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("spur_busy", 64'(busy), 64'd0);
      check("spur_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    mem_response = 1'b0;
    @(negedge clk); check("spur_after", 64'(busy), 64'd0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
